store_buffer: RTL and testbench
===============================

# store_buffer

Parametrised, in-order store buffer between the commit stage's data-FIFO write port and the data memory bus. Up to DEPTH committed stores are accepted, one per cycle, and drained to memory oldest-first under a valid/ack handshake. Loads issued by execute are checked combinationally against pending stores, so read-after-write ordering holds without waiting for the buffer to empty. It replaces the fixed single-entry data FIFO behind the pipeline top level.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, do not override)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- datafifo_addr_in  in  32  store byte address from commit
- datafifo_val_in  in  32  store data, right-justified
- datafifo_size_in  in  2  0=byte, 1=half, 2=word, 3 treated as word
- datafifo_valid_in  in  1  enqueue request
- datafifo_full  out  1  no free entry; commit must hold its store
- mem_store_addr  out  32  head entry address
- mem_store_val  out  32  head entry data
- mem_store_size  out  2  head entry size
- mem_store_valid  out  1  head entry presented to memory
- mem_store_ack  in  1  memory accepts head entry this cycle
- load_addr  in  32  load byte address from execute
- load_size  in  2  load size, same encoding
- load_query_valid  in  1  load lookup request
- load_hit  out  1  load fully covered by a pending store (forwarded)
- load_fwd_data  out  32  forwarded word, byte lanes by address[1:0]
- load_conflict  out  1  load overlaps pending store(s) and cannot be forwarded; execute stalls the load
- empty  out  1  no pending stores (used by FENCE)
- count  out  CNT_W  current occupancy

## Operation
- Circular buffer with head/tail pointers of width log2(DEPTH) plus registered count; pointers wrap modulo DEPTH.
- Enqueue: on a clk edge with datafifo_valid_in=1 and datafifo_full=0, write entry at tail, tail+1. A request while full is ignored with no state change.
- Drain: mem_store_valid = (count≠0); payload = head entry. On a clk edge with mem_store_valid=1 and mem_store_ack=1, head+1. Payload stays stable while valid and not acked.
- Simultaneous enqueue and dequeue: count unchanged. When full, enqueue is rejected even if a dequeue occurs the same edge (full derives from current count).
- Empty buffer: no bypass; an enqueued store appears on the memory port the next cycle.
- Byte mask per entry: 4-bit mask from size and addr[1:0] (byte: 1<<a, half: 3<<a, word: 4'hF), truncated to lanes 0-3. Commit never enqueues misaligned stores.
- Load check (combinational, valid only when load_query_valid=1, else outputs 0): entry matches if addr[31:2] are equal and the masks intersect. Select the youngest matching entry. load_hit=1 if its mask covers the whole load mask; load_fwd_data = its data shifted to lanes by its addr[1:0], with uncovered lanes 0. Otherwise, if any entry matches, load_conflict=1. load_hit and load_conflict are mutually exclusive.
- The entry being acked this cycle still participates in the check.

## Timing
- Reset values: count=0, pointers=0, datafifo_full=0, empty=1, mem_store_valid=0, load_hit=0, load_conflict=0, load_fwd_data=0.
- Reset mid-drain discards every pending entry. mem_store_valid is 0 in the cycle after the reset edge, regardless of ack.
- Enqueue-to-memory-valid latency: 1 cycle. Throughput: 1 store/cycle with ack held high.
- datafifo_full, empty, count and mem_store_* are functions of registered state only. load_* are combinational from load inputs and registered state, with zero latency.

## Configuration
- STORE_BUFFER_FWD_EN defined: forwarding as described above.
- Not defined: load_hit and load_fwd_data are tied to 0. Any address-word match with intersecting masks raises load_conflict, so loads wait until the overlapping stores drain.

## Test plan
- Fill DEPTH=4 with ack=0 → count=4, datafifo_full=1, a fifth enqueue is ignored. Then ack=1 for 4 cycles → addresses drained in enqueue order, empty=1.
- Full buffer, enqueue and ack on the same edge → enqueue dropped, count=3.
- Store word 0xDEADBEEF @0x100, then load byte @0x102 → load_hit=1, load_fwd_data=0xDEADBEEF (with FWD_EN). Without FWD_EN → load_conflict=1.
- Store byte 0xAA @0x201, then load word @0x200 → load_conflict=1, load_hit=0. After the store is acked, both are 0.
- Two word stores @0x300 (0x11111111, then 0x22222222), load word @0x300 → load_fwd_data=0x22222222.
- Three entries pending with mem_store_valid=1, assert reset for one edge → count=0, mem_store_valid=0, datafifo_full=0 in the next cycle.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order DEPTH-entry store buffer with load overlap check.
// Define STORE_BUFFER_FWD_EN to forward fully covered loads; otherwise any overlap raises load_conflict.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      datafifo_addr_in,
    input  logic [31:0]      datafifo_val_in,
    input  logic [1:0]       datafifo_size_in,
    input  logic             datafifo_valid_in,
    output logic             datafifo_full,
    output logic [31:0]      mem_store_addr,
    output logic [31:0]      mem_store_val,
    output logic [1:0]       mem_store_size,
    output logic             mem_store_valid,
    input  logic             mem_store_ack,
    input  logic [31:0]      load_addr,
    input  logic [1:0]       load_size,
    input  logic             load_query_valid,
    output logic             load_hit,
    output logic [31:0]      load_fwd_data,
    output logic             load_conflict,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [31:0]      val_q  [DEPTH];
    logic [31:0]      val_d  [DEPTH];
    logic [1:0]       size_q [DEPTH];
    logic [1:0]       size_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enq, deq;

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
        byte_mask = size == 2'd0 ? 4'b0001 << a : size == 2'd1 ? 4'b0011 << a : 4'hF;
    endfunction

    assign datafifo_full   = count_q == CNT_W'(DEPTH);
    assign empty           = count_q == '0;
    assign count           = count_q;
    assign mem_store_valid = !empty;
    assign mem_store_addr  = addr_q[head_q];
    assign mem_store_val   = val_q[head_q];
    assign mem_store_size  = size_q[head_q];
    assign enq             = datafifo_valid_in && !datafifo_full;
    assign deq             = mem_store_valid && mem_store_ack;

    always_comb begin
        addr_d  = addr_q;
        val_d   = val_q;
        size_d  = size_q;
        if (enq) begin
            addr_d[tail_q] = datafifo_addr_in;
            val_d[tail_q]  = datafifo_val_in;
            size_d[tail_q] = datafifo_size_in;
        end
        head_d  = head_q + PW'(deq);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            val_q[i]  <= val_d[i];
            size_q[i] <= size_d[i];
        end
    end

    // Scan oldest to youngest so the last match is the youngest overlapping store.
    logic [3:0]    lmask, emask;
    logic [PW-1:0] idx;
    logic          any_match;
`ifdef STORE_BUFFER_FWD_EN
    logic [3:0]    ymask;
    logic [31:0]   ydata, lane_mask;
`endif

    always_comb begin
        lmask     = byte_mask(load_size, load_addr[1:0]);
        emask     = '0;
        idx       = '0;
        any_match = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        ymask     = '0;
        ydata     = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx   = head_q + PW'(i);
            emask = byte_mask(size_q[idx], addr_q[idx][1:0]);
            if (CNT_W'(i) < count_q && addr_q[idx][31:2] == load_addr[31:2] && |(emask & lmask)) begin
                any_match = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                ymask     = emask;
                ydata     = val_q[idx] << {addr_q[idx][1:0], 3'b000};
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign lane_mask     = {{8{ymask[3]}}, {8{ymask[2]}}, {8{ymask[1]}}, {8{ymask[0]}}};
    assign load_hit      = load_query_valid && any_match && (ymask & lmask) == lmask;
    assign load_fwd_data = load_hit ? ydata & lane_mask : '0;
    assign load_conflict = load_query_valid && any_match && !load_hit;
`else
    assign load_hit      = 1'b0;
    assign load_fwd_data = '0;
    assign load_conflict = load_query_valid && any_match;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus against a byte-range queue model of store_buffer.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 0;
    logic             reset = 1;
    logic [31:0]      datafifo_addr_in = 0, datafifo_val_in = 0;
    logic [1:0]       datafifo_size_in = 0;
    logic             datafifo_valid_in = 0;
    logic             datafifo_full;
    logic [31:0]      mem_store_addr, mem_store_val;
    logic [1:0]       mem_store_size;
    logic             mem_store_valid;
    logic             mem_store_ack = 0;
    logic [31:0]      load_addr = 0;
    logic [1:0]       load_size = 0;
    logic             load_query_valid = 0;
    logic             load_hit, load_conflict;
    logic [31:0]      load_fwd_data;
    logic             empty;
    logic [CNT_W-1:0] count;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .datafifo_addr_in(datafifo_addr_in), .datafifo_val_in(datafifo_val_in),
        .datafifo_size_in(datafifo_size_in), .datafifo_valid_in(datafifo_valid_in),
        .datafifo_full(datafifo_full),
        .mem_store_addr(mem_store_addr), .mem_store_val(mem_store_val),
        .mem_store_size(mem_store_size), .mem_store_valid(mem_store_valid),
        .mem_store_ack(mem_store_ack),
        .load_addr(load_addr), .load_size(load_size), .load_query_valid(load_query_valid),
        .load_hit(load_hit), .load_fwd_data(load_fwd_data), .load_conflict(load_conflict),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
    } st_t;

    st_t q[$];
    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_on = 0;

    function automatic void cmp(string n, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endfunction

    function automatic int len_of(logic [1:0] s);
        return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    endfunction

    // Stores and loads as byte ranges; the youngest overlapping store decides.
    function automatic void model_load(output logic hit, output logic conf, output logic [31:0] data);
        longint la = longint'(load_addr);
        longint ll = longint'(len_of(load_size));
        int     y = -1;
        bit     cov;
        logic [31:0] fd = 0;
        hit = 0; conf = 0; data = 0;
        if (!load_query_valid) return;
        foreach (q[i]) begin
            longint sa = longint'(q[i].a);
            longint sl = longint'(len_of(q[i].s));
            if (sa < la + ll && la < sa + sl) y = i;
        end
        if (y < 0) return;
        cov = longint'(q[y].a) <= la && la + ll <= longint'(q[y].a) + longint'(len_of(q[y].s));
        for (int b = 0; b < len_of(q[y].s); b++)
            fd[8*((int'(q[y].a[1:0]) + b) % 4) +: 8] = q[y].d[8*b +: 8];
`ifdef STORE_BUFFER_FWD_EN
        hit  = cov;
        conf = !cov;
        data = cov ? fd : 0;
`else
        conf = 1;
`endif
    endfunction

    always @(negedge clk) if (chk_on) begin
        logic h, c;
        logic [31:0] d;
        cmp("count", 32'(count), 32'(q.size()));
        cmp("full", 32'(datafifo_full), 32'(q.size() == DEPTH));
        cmp("empty", 32'(empty), 32'(q.size() == 0));
        cmp("mem_valid", 32'(mem_store_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            cmp("mem_addr", mem_store_addr, q[0].a);
            cmp("mem_val", mem_store_val, q[0].d);
            cmp("mem_size", 32'(mem_store_size), 32'(q[0].s));
        end
        model_load(h, c, d);
        cmp("load_hit", 32'(load_hit), 32'(h));
        cmp("load_conflict", 32'(load_conflict), 32'(c));
        cmp("load_fwd_data", load_fwd_data, d);
    end

    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic ack, input logic rst);
        bit enq, deq;
        datafifo_valid_in = v; datafifo_addr_in = a; datafifo_val_in = d;
        datafifo_size_in = s; mem_store_ack = ack; reset = rst;
        enq = v && q.size() < DEPTH;
        deq = ack && q.size() > 0;
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (deq) void'(q.pop_front());
            if (enq) q.push_back('{a: a, d: d, s: s});
        end
        #1;
    endtask

    task automatic idle(input logic ack);
        cyc(0, 0, 0, 0, ack, 0);
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] s);
        load_addr = a; load_size = s; load_query_valid = 1; #1;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        chk_on = 1;
        cyc(0, 0, 0, 0, 0, 1);
        cmp("rst_count", 32'(count), 0);
        cmp("rst_empty", 32'(empty), 1);
        cmp("rst_valid", 32'(mem_store_valid), 0);
        cmp("rst_full", 32'(datafifo_full), 0);
        cmp("rst_conflict", 32'(load_conflict), 0);

        for (int i = 0; i < 4; i++) cyc(1, 32'h10 + 4*i, 32'hA0 + i, 2, 0, 0);
        cmp("fill_count", 32'(count), 4);
        cmp("fill_full", 32'(datafifo_full), 1);
        cyc(1, 32'h20, 32'hFF, 2, 0, 0);
        cmp("fifth_ignored", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            cmp("drain_addr", mem_store_addr, 32'h10 + 4*i);
            idle(1);
        end
        cmp("drain_empty", 32'(empty), 1);

        for (int i = 0; i < 4; i++) cyc(1, 32'h40 + 4*i, 32'hB0 + i, 2, 0, 0);
        cyc(1, 32'h50, 32'hEE, 2, 1, 0);
        cmp("full_enq_deq_count", 32'(count), 3);
        cmp("full_enq_deq_head", mem_store_addr, 32'h44);
        for (int i = 0; i < 3; i++) idle(1);

        for (int i = 0; i < 5; i++) cyc(1, 32'h80 + 4*i, 32'hC0 + i, 2'(i), 1, 0);
        idle(1);
        cmp("stream_empty", 32'(empty), 1);

        cyc(1, 32'h100, 32'hDEADBEEF, 2, 0, 0);
        load(32'h102, 0);
`ifdef STORE_BUFFER_FWD_EN
        cmp("fwd_word_hit", 32'(load_hit), 1);
        cmp("fwd_word_data", load_fwd_data, 32'hDEADBEEF);
`else
        cmp("nofwd_conflict", 32'(load_conflict), 1);
        cmp("nofwd_hit", 32'(load_hit), 0);
`endif
        load(32'h104, 2);
        cmp("other_word_conflict", 32'(load_conflict), 0);
        idle(0);
        idle(1);
        load_query_valid = 0;

        cyc(1, 32'h201, 32'h000000AA, 0, 0, 0);
        load(32'h200, 2);
        cmp("partial_conflict", 32'(load_conflict), 1);
        cmp("partial_hit", 32'(load_hit), 0);
        load(32'h203, 0);
        cmp("disjoint_byte", 32'(load_conflict), 0);
        load(32'h201, 0);
        idle(0);
        load(32'h200, 2);
        idle(1);
        cmp("acked_conflict", 32'(load_conflict), 0);
        cmp("acked_hit", 32'(load_hit), 0);
        load_query_valid = 0;

        cyc(1, 32'h300, 32'h11111111, 2, 0, 0);
        cyc(1, 32'h300, 32'h22222222, 2, 0, 0);
        load(32'h300, 2);
`ifdef STORE_BUFFER_FWD_EN
        cmp("youngest_data", load_fwd_data, 32'h22222222);
`else
        cmp("youngest_conflict", 32'(load_conflict), 1);
`endif
        cyc(1, 32'h402, 32'h0000BEEF, 1, 1, 0);
        load(32'h403, 0);
`ifdef STORE_BUFFER_FWD_EN
        cmp("half_lane_data", load_fwd_data, 32'hBEEF0000);
`endif
        idle(0);
        load(32'h400, 1);
        idle(0);
        load(32'h401, 1);
        idle(1);
        load(32'h300, 2);
        idle(1);
        idle(1);
        load_query_valid = 0;

        for (int i = 0; i < 3; i++) cyc(1, 32'h600 + 4*i, 32'hD0 + i, 2, 0, 0);
        cmp("pre_reset_count", 32'(count), 3);
        cyc(0, 0, 0, 0, 1, 1);
        cmp("mid_reset_count", 32'(count), 0);
        cmp("mid_reset_valid", 32'(mem_store_valid), 0);
        cmp("mid_reset_full", 32'(datafifo_full), 0);
        idle(1);
        idle(0);

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
